// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants and helpers for the 4-queue schedulers.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int NQ    = 4;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction

  // First non-empty queue, searching start, start+1, ... with index wrap.
  function automatic pick_t rr_pick(input logic [NQ-1:0]    empty,
                                    input logic [SEL_W-1:0] start);
    pick_t            r;
    logic [SEL_W-1:0] k;
    r.found = 1'b0;
    r.idx   = start;
    k       = start;
    for (int j = 0; j < NQ; j++) begin
      if (!r.found && !empty[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
      k = next_idx(k);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotate-priority encoder over four empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NQ-1:0]    empty,
  input  logic [SEL_W-1:0] start,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  pick_t w_pick;

  always_comb begin
    w_pick = rr_pick(empty, start);
  end

  assign valid = w_pick.found;
  assign idx   = w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Quantum round-robin scheduler for the 4-queue egress stage.
//               Optional macro ARB_PRIO0_EN makes queue 0 strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int QUANTUM = 1,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NQ-1:0]    fifo_empty,
  input  logic             ds_almost_full,
  output logic [NQ-1:0]    pop,
  output logic [SEL_W-1:0] select,
  output logic             push,
  output logic             grant_valid
);

  localparam logic [CNT_W:0] c_quantum = (CNT_W+1)'(QUANTUM);

  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel_q;
  logic             r_push_q;

  logic [NQ-1:0]    w_search_empty;
  logic             w_prio0;
  logic             w_rr_valid;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W-1:0] w_win;
  logic             w_eligible;
  logic [CNT_W:0]   w_n;

`ifdef ARB_PRIO0_EN
  // Queue 0 bypasses the rotation entirely; the search only ever sees 1..3.
  assign w_search_empty = fifo_empty | NQ'(1);
  assign w_prio0        = ~fifo_empty[0];
`else
  assign w_search_empty = fifo_empty;
  assign w_prio0        = 1'b0;
`endif

  rr_pick4 u_pick (
    .empty (w_search_empty),
    .start (r_ptr),
    .valid (w_rr_valid),
    .idx   (w_rr_idx)
  );

  assign w_eligible = ~ds_almost_full & (w_prio0 | w_rr_valid);
  assign w_win      = w_prio0 ? '0 : w_rr_idx;

  // Words served to the winner including this one; restarts when the grant moves.
  assign w_n = (w_rr_idx == r_ptr) ? ({1'b0, r_cnt} + 1'b1) : (CNT_W+1)'(1);

  always_comb begin
    pop = '0;
    if (reset && w_eligible) begin
      pop[w_win] = 1'b1;
    end
  end

  assign grant_valid = |pop;
  assign select      = r_sel_q;
  assign push        = r_push_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_sel_q  <= '0;
      r_push_q <= 1'b0;
    end else if (w_eligible) begin
      r_sel_q  <= w_win;
      r_push_q <= 1'b1;
      if (!w_prio0) begin
        if (w_n == c_quantum) begin
          r_ptr <= next_idx(w_rr_idx);
          r_cnt <= '0;
        end else begin
          r_ptr <= w_rr_idx;
          r_cnt <= w_n[CNT_W-1:0];
        end
      end
    end else begin
      r_push_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter4
// Description : Directed self-checking bench, QUANTUM=1 and QUANTUM=3 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

  logic       clk;
  logic       reset;
  logic [3:0] fifo_empty;
  logic       ds_almost_full;

  logic [3:0] pop1, pop3;
  logic [1:0] sel1, sel3;
  logic       push1, push3;
  logic       gv1, gv3;

  int checks = 0;
  int errors = 0;

  rr_arbiter4 #(.QUANTUM(1), .CNT_W(4)) dut_q1 (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .ds_almost_full (ds_almost_full),
    .pop            (pop1),
    .select         (sel1),
    .push           (push1),
    .grant_valid    (gv1)
  );

  rr_arbiter4 #(.QUANTUM(3), .CNT_W(4)) dut_q3 (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .ds_almost_full (ds_almost_full),
    .pop            (pop3),
    .select         (sel3),
    .push           (push3),
    .grant_valid    (gv3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at a negedge with reset just released (cycle 0).
  task automatic do_reset();
    reset          = 1'b0;
    fifo_empty     = 4'b0000;
    ds_almost_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    fifo_empty     = 4'b0000;
    ds_almost_full = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (pop1 !== 4'b0000 || gv1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_pop1 k=%0d got pop=%b gv=%b want 0000/0", k, pop1, gv1);
      end
      checks++;
      if (push1 !== 1'b0 || sel1 !== 2'd0) begin
        errors++;
        $display("FAIL reset_regs1 k=%0d got push=%b sel=%0d want 0/0", k, push1, sel1);
      end
      checks++;
      if (pop3 !== 4'b0000 || push3 !== 1'b0 || sel3 !== 2'd0) begin
        errors++;
        $display("FAIL reset_dut3 k=%0d got pop=%b push=%b sel=%0d want 0000/0/0", k, pop3, push3, sel3);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (pop1 !== 4'b0001 || gv1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release1 got pop=%b gv=%b want 0001/1", pop1, gv1);
    end
    checks++;
    if (pop3 !== 4'b0001) begin
      errors++;
      $display("FAIL reset_release3 got pop=%b want 0001", pop3);
    end
  endtask

  task automatic test_fair_rotation();
    logic [3:0] exp_pop [8];
    exp_pop = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (pop1 !== exp_pop[k]) begin
        errors++;
        $display("FAIL rot_pop k=%0d got %b want %b", k, pop1, exp_pop[k]);
      end
      checks++;
      if (k == 0) begin
        if (push1 !== 1'b0) begin
          errors++;
          $display("FAIL rot_push0 got %b want 0", push1);
        end
      end else if (push1 !== 1'b1 || sel1 !== 2'((k - 1) % 4)) begin
        errors++;
        $display("FAIL rot_trail k=%0d got push=%b sel=%0d want 1/%0d", k, push1, sel1, (k - 1) % 4);
      end
    end
  endtask

  task automatic test_skip_wrap();
    logic [3:0] exp_pop [7];
    exp_pop = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      fifo_empty = (k < 3) ? 4'b0000 : 4'b1010;
      #1;
      checks++;
      if (pop1 !== exp_pop[k]) begin
        errors++;
        $display("FAIL skip_pop k=%0d got %b want %b", k, pop1, exp_pop[k]);
      end
    end
  endtask

  task automatic test_quantum();
    logic [3:0] exp_a [12];
    logic [3:0] exp_b [8];
    exp_a = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
              4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
    exp_b = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (pop3 !== exp_a[k]) begin
        errors++;
        $display("FAIL quantum_pop k=%0d got %b want %b", k, pop3, exp_a[k]);
      end
    end
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      fifo_empty = (k < 4) ? 4'b0000 : 4'b0010;
      #1;
      checks++;
      if (pop3 !== exp_b[k]) begin
        errors++;
        $display("FAIL forfeit_pop k=%0d got %b want %b", k, pop3, exp_b[k]);
      end
      if (k == 4) begin
        checks++;
        if (push3 !== 1'b1 || sel3 !== 2'd1) begin
          errors++;
          $display("FAIL forfeit_trail got push=%b sel=%0d want 1/1", push3, sel3);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_p1 [9];
    logic [3:0] exp_p3 [9];
    logic       exp_push [9];
    logic [1:0] exp_s1 [9];
    logic [1:0] exp_s3 [9];
    exp_p1   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0100};
    exp_p3   = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0100};
    exp_push = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_s1   = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    exp_s3   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      ds_almost_full = (k == 5 || k == 6);
      #1;
      checks++;
      if (pop1 !== exp_p1[k] || gv1 !== (exp_p1[k] != 4'b0000)) begin
        errors++;
        $display("FAIL bp_pop1 k=%0d got pop=%b gv=%b want %b", k, pop1, gv1, exp_p1[k]);
      end
      checks++;
      if (pop3 !== exp_p3[k]) begin
        errors++;
        $display("FAIL bp_pop3 k=%0d got %b want %b", k, pop3, exp_p3[k]);
      end
      checks++;
      if (push1 !== exp_push[k] || sel1 !== exp_s1[k]) begin
        errors++;
        $display("FAIL bp_regs1 k=%0d got push=%b sel=%0d want %b/%0d", k, push1, sel1, exp_push[k], exp_s1[k]);
      end
      checks++;
      if (push3 !== exp_push[k] || sel3 !== exp_s3[k]) begin
        errors++;
        $display("FAIL bp_regs3 k=%0d got push=%b sel=%0d want %b/%0d", k, push3, sel3, exp_push[k], exp_s3[k]);
      end
    end
    ds_almost_full = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (pop1 !== 4'b0000 || gv1 !== 1'b0 || push1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_enter got pop=%b gv=%b push=%b want 0000/0/1", pop1, gv1, push1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (push1 !== 1'b0 || sel1 !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_clear got push=%b sel=%0d want 0/0", push1, sel1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (pop1 !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_ptr got pop=%b want 0001", pop1);
    end
  endtask

  task automatic test_prio0();
    logic [3:0] exp_p1 [8];
    logic [3:0] exp_p3 [8];
    exp_p1 = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b0100};
    exp_p3 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0100};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      fifo_empty = (k < 2 || k == 6) ? 4'b0000 : 4'b0001;
      #1;
      checks++;
      if (pop1 !== exp_p1[k]) begin
        errors++;
        $display("FAIL prio_pop1 k=%0d got %b want %b", k, pop1, exp_p1[k]);
      end
      checks++;
      if (pop3 !== exp_p3[k]) begin
        errors++;
        $display("FAIL prio_pop3 k=%0d got %b want %b", k, pop3, exp_p3[k]);
      end
    end
  endtask

  initial begin
    reset          = 1'b0;
    fifo_empty     = 4'b0000;
    ds_almost_full = 1'b0;
    test_reset();
`ifdef ARB_PRIO0_EN
    test_prio0();
`else
    test_fair_rotation();
    test_skip_wrap();
    test_quantum();
    test_backpressure();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
